kp_filter3x3_top: RTL and testbench

- Parametrised successor to the single-channel gaussian top.
- Reads packed multi-channel pixels (e.g. R,G,B) from a first-word-fall-through input FIFO.
- Applies a run-time selectable 3x3 kernel to each channel independently, using internal line buffers, and writes results into an internal sync output FIFO.
- Adds output-FIFO backpressure on input reads, frame-aligned mode switching and a frame-done pulse; sits between the capture FIFO and the colour-detect stage.

---
 rtl/kp_filter3x3_top.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_kp_filter3x3_top.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kp_filter3x3_top.sv
// kp_filter3x3_top
// -----------------------------------------------------------------------------
// Multi-channel 3x3 filter stage between the capture FIFO and colour detect.
// Pixels are pulled from a first-word-fall-through input FIFO, each channel is
// filtered independently with a run-time selected kernel, and results are
// pushed into an internal synchronous output FIFO.
//
// Optional feature macro: KP_FILTER3X3_STATS_EN (frame counter on o_frame_count).
//
// Ports
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_flush                synchronous clear of datapath, counters, output FIFO
//   i_mode                 0 bypass, 1 gaussian 3x3, 2 horizontal 1x3, 3 bypass
//   i_data, i_almostempty  input FIFO head (valid while o_rd high) and flag
//   o_rd                   input FIFO read strobe (registered)
//   i_obuf_rd              output FIFO pop
//   o_obuf_data/fill/...   output FIFO head, occupancy and flags
//   o_active_mode          mode applied to the current frame
//   o_frame_done           one-cycle pulse after the last output of a frame
//   o_frame_count          completed frames (zero without the stats macro)
//
// Handshake: a pixel is accepted in every cycle where o_rd is high; i_data is
// sampled in that same cycle. The output FIFO pops on i_obuf_rd when not empty.
module kp_filter3x3_top #(
    parameter int LINE_LENGTH    = 640,
    parameter int LINE_COUNT     = 480,
    parameter int DATA_WIDTH     = 8,
    parameter int CHANNELS       = 3,
    parameter int OBUF_PTR_WIDTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic                           i_flush,
    input  logic [1:0]                     i_mode,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
    input  logic                           i_almostempty,
    output logic                           o_rd,
    input  logic                           i_obuf_rd,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_obuf_data,
    output logic [OBUF_PTR_WIDTH:0]        o_obuf_fill,
    output logic                           o_obuf_full,
    output logic                           o_obuf_almostfull,
    output logic                           o_obuf_empty,
    output logic                           o_obuf_almostempty,
    output logic [1:0]                     o_active_mode,
    output logic                           o_frame_done,
    output logic [15:0]                    o_frame_count
);

    localparam int PW    = CHANNELS * DATA_WIDTH;
    localparam int SW    = DATA_WIDTH + 4;
    localparam int DEPTH = 1 << OBUF_PTR_WIDTH;
    localparam int CW    = $clog2(LINE_LENGTH);
    localparam int RW    = $clog2(LINE_COUNT);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} rd_state_t;

    rd_state_t state_q, state_d;
    logic      rd_d, rd_q;
    logic      accept;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last, row_last;
    logic [1:0]    mode_q, mode_d;
    logic          gauss, horiz, filt, emit;

    logic          v1_q, v2_q, v3_q;
    logic          last1_q, last2_q, last3_q;
    logic          frame_done_q;

    logic [PW-1:0] lb1_mem [LINE_LENGTH];
    logic [PW-1:0] lb2_mem [LINE_LENGTH];
    logic [PW-1:0] win_q   [3][3];
    logic [SW-1:0] sum_d   [CHANNELS];
    logic [SW-1:0] sum_q   [CHANNELS];
    logic [PW-1:0] res_d, res_q;

    logic [PW-1:0]             obuf_mem [DEPTH];
    logic [OBUF_PTR_WIDTH:0]   wptr_q, rptr_q, fill;
    logic                      wr, wr_last, do_wr, do_rd;
    logic [PW-1:0]             wdata;
    logic [1:0]                inflight;
    logic [OBUF_PTR_WIDTH+1:0] load;
    logic                      go;

    // ------------------------------------------------------------------
    // Read FSM. Pixels already inside the pipeline count against the output
    // FIFO space so that the FIFO can never overflow once they land.
    // ------------------------------------------------------------------
    assign accept   = rd_q;
    assign inflight = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q};
    assign load     = {1'b0, fill} + {{OBUF_PTR_WIDTH{1'b0}}, inflight};
    assign go       = !i_almostempty && (load <= (OBUF_PTR_WIDTH+2)'(DEPTH - 4));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            rd_q    <= 1'b0;
        end else if (i_flush) begin
            state_q <= ST_IDLE;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (go)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (!go) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_d = 1'b0;
        case (state_q)
            ST_IDLE:   rd_d = go;
            ST_ACTIVE: rd_d = go;
            default:   rd_d = 1'b0;
        endcase
    end

    assign o_rd = rd_q;

    // ------------------------------------------------------------------
    // Pixel position and frame-aligned mode latch
    // ------------------------------------------------------------------
    assign col_last = (col_q == CW'(LINE_LENGTH - 1));
    assign row_last = (row_q == RW'(LINE_COUNT - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // The mode only changes while the pipeline is empty, so every stage can
    // use mode_q directly and a bypass write can never collide with the tail
    // of a filtered frame.
    always_comb begin
        mode_d = mode_q;
        if ((col_q == '0) && (row_q == '0) && !accept && !v1_q && !v2_q && !v3_q)
            mode_d = i_mode;
    end

    assign gauss = (mode_q == 2'd1);
    assign horiz = (mode_q == 2'd2);
    assign filt  = gauss || horiz;

    always_comb begin
        emit = 1'b1;
        if (gauss)      emit = (col_q >= CW'(2)) && (row_q >= RW'(2));
        else if (horiz) emit = (col_q >= CW'(2));
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= 2'd0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            last1_q      <= 1'b0;
            last2_q      <= 1'b0;
            last3_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (i_flush) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= 2'd0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            last1_q      <= 1'b0;
            last2_q      <= 1'b0;
            last3_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            v1_q         <= accept && emit;
            last1_q      <= accept && col_last && row_last;
            v2_q         <= v1_q && filt;
            last2_q      <= last1_q;
            v3_q         <= v2_q;
            last3_q      <= last2_q;
            frame_done_q <= wr && wr_last;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and window. Row 0 of the window is row r-2, row 2 is the
    // current row; column 2 is the newest pixel.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1_mem[col_q] <= i_data;
            lb2_mem[col_q] <= lb1_mem[col_q];
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
            end
            win_q[0][2] <= lb2_mem[col_q];
            win_q[1][2] <= lb1_mem[col_q];
            win_q[2][2] <= i_data;
        end
    end

    function automatic logic [SW-1:0] px(input logic [PW-1:0] w, input int ch);
        return SW'(w[ch*DATA_WIDTH +: DATA_WIDTH]);
    endfunction

    // Weighted sums; at most 16 * (2**DATA_WIDTH - 1), which fits in SW bits.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            sum_d[ch] = '0;
            if (gauss) begin
                sum_d[ch] = px(win_q[0][0], ch) + (px(win_q[0][1], ch) << 1) + px(win_q[0][2], ch)
                          + (px(win_q[1][0], ch) << 1) + (px(win_q[1][1], ch) << 2)
                          + (px(win_q[1][2], ch) << 1)
                          + px(win_q[2][0], ch) + (px(win_q[2][1], ch) << 1) + px(win_q[2][2], ch);
            end else begin
                sum_d[ch] = px(win_q[2][0], ch) + (px(win_q[2][1], ch) << 1) + px(win_q[2][2], ch);
            end
        end
    end

    always_comb begin
        res_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (gauss)
                res_d[ch*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((sum_q[ch] + SW'(8)) >> 4);
            else
                res_d[ch*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((sum_q[ch] + SW'(2)) >> 2);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            sum_q[ch] <= sum_d[ch];
        end
        res_q <= res_d;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    assign wr      = filt ? v3_q : v1_q;
    assign wr_last = filt ? last3_q : last1_q;
    assign wdata   = filt ? res_q : win_q[2][2];

    assign fill  = wptr_q - rptr_q;
    assign do_wr = wr && !o_obuf_full;
    assign do_rd = i_obuf_rd && !o_obuf_empty;

    always_ff @(posedge i_clk) begin
        if (do_wr) obuf_mem[wptr_q[OBUF_PTR_WIDTH-1:0]] <= wdata;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (i_flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + (OBUF_PTR_WIDTH+1)'(1);
            if (do_rd) rptr_q <= rptr_q + (OBUF_PTR_WIDTH+1)'(1);
        end
    end

    assign o_obuf_data        = obuf_mem[rptr_q[OBUF_PTR_WIDTH-1:0]];
    assign o_obuf_fill        = fill;
    assign o_obuf_full        = (fill == (OBUF_PTR_WIDTH+1)'(DEPTH));
    assign o_obuf_almostfull  = (fill >= (OBUF_PTR_WIDTH+1)'(DEPTH - 2));
    assign o_obuf_empty       = (fill == '0);
    assign o_obuf_almostempty = (fill <= (OBUF_PTR_WIDTH+1)'(1));
    assign o_active_mode      = mode_q;
    assign o_frame_done       = frame_done_q;

`ifdef KP_FILTER3X3_STATS_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)           frame_count_q <= '0;
        else if (i_flush)      frame_count_q <= '0;
        else if (frame_done_q) frame_count_q <= frame_count_q + 16'd1;
    end

    assign o_frame_count = frame_count_q;
`else
    assign o_frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_kp_filter3x3_top.sv
module tb_kp_filter3x3_top;

    localparam int LL    = 8;
    localparam int LC    = 4;
    localparam int DW    = 8;
    localparam int CH    = 3;
    localparam int PW    = CH * DW;
    localparam int PTRW  = 4;
    localparam int DEPTH = 16;

    logic            clk   = 1'b0;
    logic            rstn  = 1'b0;
    logic            flush = 1'b0;
    logic [1:0]      mode  = 2'd0;
    logic [PW-1:0]   in_data = '0;
    logic            in_ae = 1'b1;
    logic            rd;
    logic            ob_rd = 1'b0;
    logic [PW-1:0]   ob_data;
    logic [PTRW:0]   ob_fill;
    logic            ob_full, ob_af, ob_empty, ob_ae;
    logic [1:0]      act_mode;
    logic            fdone;
    logic [15:0]     fcount;

    always #5 clk = ~clk;

    kp_filter3x3_top #(
        .LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(DW),
        .CHANNELS(CH), .OBUF_PTR_WIDTH(PTRW)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_mode(mode),
        .i_data(in_data), .i_almostempty(in_ae), .o_rd(rd),
        .i_obuf_rd(ob_rd), .o_obuf_data(ob_data), .o_obuf_fill(ob_fill),
        .o_obuf_full(ob_full), .o_obuf_almostfull(ob_af),
        .o_obuf_empty(ob_empty), .o_obuf_almostempty(ob_ae),
        .o_active_mode(act_mode), .o_frame_done(fdone), .o_frame_count(fcount)
    );

    logic [PW-1:0] in_q  [$];
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] frm   [LC][LL];

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          rd_pct    = 100;
    int          stall_pct = 0;
    int          accepted  = 0;
    int          fd_seen   = 0;
    int          fd_exp    = 0;
    int          base      = 0;
    int          guard     = 0;
    logic [15:0] fc_exp    = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: outputs of one frame from plain kernel arithmetic.
    task automatic push_frame(input int m);
        int s;
        logic [PW-1:0] o;
        for (int r = 0; r < LC; r++)
            for (int c = 0; c < LL; c++)
                in_q.push_back(frm[r][c]);
        for (int r = 0; r < LC; r++) begin
            for (int c = 0; c < LL; c++) begin
                if (m == 1) begin
                    if (r >= 2 && c >= 2) begin
                        o = '0;
                        for (int ch = 0; ch < CH; ch++) begin
                            s = 0;
                            for (int dr = 0; dr < 3; dr++)
                                for (int dc = 0; dc < 3; dc++)
                                    s += ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1)
                                         * int'(frm[r-2+dr][c-2+dc][ch*DW +: DW]);
                            o[ch*DW +: DW] = DW'((s + 8) / 16);
                        end
                        exp_q.push_back(o);
                    end
                end else if (m == 2) begin
                    if (c >= 2) begin
                        o = '0;
                        for (int ch = 0; ch < CH; ch++) begin
                            s = int'(frm[r][c-2][ch*DW +: DW]) + 2 * int'(frm[r][c-1][ch*DW +: DW])
                              + int'(frm[r][c][ch*DW +: DW]);
                            o[ch*DW +: DW] = DW'((s + 2) / 4);
                        end
                        exp_q.push_back(o);
                    end
                end else begin
                    exp_q.push_back(frm[r][c]);
                end
            end
        end
        fd_exp++;
        fc_exp = fc_exp + 16'd1;
    endtask

    // One clock: monitor and drive at the falling edge, consume at the rising edge.
    task automatic step();
        logic rd_s, ord_s;
        @(negedge clk);
        if (fdone) fd_seen++;
        check_eq("fill_bound", 32'(ob_fill <= DEPTH), 32'd1);
        check_eq("full_flag", 32'(ob_full), 32'(ob_fill == DEPTH));
        check_eq("almostfull_flag", 32'(ob_af), 32'(ob_fill >= DEPTH - 2));
        check_eq("empty_flag", 32'(ob_empty), 32'(ob_fill == 0));
        check_eq("almostempty_flag", 32'(ob_ae), 32'(ob_fill <= 1));
        rd_s = rd;
        check_eq("rd_on_empty_input", 32'(rd_s && in_q.size() == 0), 32'd0);
        in_data = (in_q.size() != 0) ? in_q[0] : '0;
        in_ae = ($urandom_range(99) < stall_pct) || (in_q.size() <= (rd_s ? 1 : 0));
        ord_s = !ob_empty && ($urandom_range(99) < rd_pct);
        ob_rd = ord_s;
        if (ord_s) begin
            check_eq("output_available", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("obuf_data", 32'(ob_data), 32'(exp_q[0]));
                exp_q.delete(0);
            end
        end
        @(posedge clk);
        if (rd_s && in_q.size() != 0) begin
            in_q.delete(0);
            accepted++;
        end
        #1;
    endtask

    task automatic check_counts();
        logic [15:0] fc_want;
`ifdef KP_FILTER3X3_STATS_EN
        fc_want = fc_exp;
`else
        fc_want = 16'd0;
`endif
        check_eq("frame_done_count", 32'(fd_seen), 32'(fd_exp));
        check_eq("frame_count", 32'(fcount), 32'(fc_want));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_in_time", 32'(n < budget), 32'd1);
        repeat (8) step();
        check_eq("fill_after_frame", 32'(ob_fill), 32'd0);
        check_counts();
    endtask

    task automatic frame_gap(input logic [1:0] m);
        mode = m;
        repeat (8) step();
        check_eq("active_mode", 32'(act_mode), 32'(m));
    endtask

    task automatic fill_random();
        for (int r = 0; r < LC; r++)
            for (int c = 0; c < LL; c++)
                frm[r][c] = PW'($urandom);
    endtask

    task automatic wait_accepts(input int n);
        base  = accepted;
        guard = 0;
        while (accepted < base + n && guard < 500) begin
            step();
            guard++;
        end
        check_eq("accept_progress", 32'(guard < 500), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd"}, 32'(rd), 32'd0);
        check_eq({tag, "_fill"}, 32'(ob_fill), 32'd0);
        check_eq({tag, "_empty"}, 32'(ob_empty), 32'd1);
        check_eq({tag, "_almostempty"}, 32'(ob_ae), 32'd1);
        check_eq({tag, "_full"}, 32'(ob_full), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(fdone), 32'd0);
        check_eq({tag, "_active_mode"}, 32'(act_mode), 32'd0);
        check_eq({tag, "_frame_count"}, 32'(fcount), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check_eq("reset_almostfull", 32'(ob_af), 32'd0);
        rstn = 1'b1;

        // Bypass, index pattern replicated on every channel.
        for (int r = 0; r < LC; r++)
            for (int c = 0; c < LL; c++)
                frm[r][c] = {CH{DW'(r * LL + c)}};
        frame_gap(2'd0);
        push_frame(0);
        drain(2000);

        // Gaussian on saturated input.
        for (int r = 0; r < LC; r++)
            for (int c = 0; c < LL; c++)
                frm[r][c] = {CH{8'hFF}};
        frame_gap(2'd1);
        push_frame(1);
        drain(2000);

        // Gaussian impulse response.
        for (int r = 0; r < LC; r++)
            for (int c = 0; c < LL; c++)
                frm[r][c] = '0;
        frm[1][1] = {CH{8'h10}};
        frame_gap(2'd1);
        push_frame(1);
        drain(2000);

        // Horizontal blur on a ramp.
        for (int r = 0; r < LC; r++)
            for (int c = 0; c < LL; c++)
                frm[r][c] = {CH{DW'(4 * c)}};
        frame_gap(2'd2);
        push_frame(2);
        drain(2000);

        // Random frames, modes, read rates and input stalls.
        for (int k = 0; k < 8; k++) begin
            int m;
            m = int'($urandom_range(3));
            rd_pct = int'($urandom_range(100, 30));
            stall_pct = int'($urandom_range(30, 0));
            fill_random();
            frame_gap(2'(m));
            push_frame((m == 3) ? 0 : m);
            drain(4000);
        end
        rd_pct = 100;
        stall_pct = 0;

        // Backpressure: nobody reads the output FIFO.
        fill_random();
        frame_gap(2'd0);
        rd_pct = 0;
        push_frame(0);
        repeat (60) step();
        check_eq("bp_rd_stopped", 32'(rd), 32'd0);
        check_eq("bp_fill_reached", 32'(ob_fill >= 12), 32'd1);
        check_eq("bp_not_full", 32'(ob_full), 32'd0);
        check_eq("bp_input_left", 32'(in_q.size() > 0), 32'd1);
        rd_pct = 100;
        drain(2000);

        // Mid-frame mode change is deferred to the next frame.
        fill_random();
        frame_gap(2'd0);
        push_frame(0);
        wait_accepts(10);
        mode = 2'd1;
        repeat (2) step();
        check_eq("mode_hold_midframe", 32'(act_mode), 32'd0);
        drain(2000);
        fill_random();
        frame_gap(2'd1);
        push_frame(1);
        drain(2000);

        // Flush mid-frame; next frame restarts at row 0, col 0.
        fill_random();
        push_frame(1);
        wait_accepts(12);
        @(negedge clk);
        flush = 1'b1;
        ob_rd = 1'b0;
        in_ae = 1'b1;
        in_q.delete();
        exp_q.delete();
        fd_exp--;
        fc_exp = 16'd0;
        @(negedge clk);
        flush = 1'b0;
        check_reset_outputs("flush");
        fill_random();
        frame_gap(2'd1);
        push_frame(1);
        drain(2000);

        // Asynchronous reset mid-frame.
        fill_random();
        push_frame(1);
        wait_accepts(15);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        in_q.delete();
        exp_q.delete();
        fd_exp--;
        fc_exp = 16'd0;
        ob_rd = 1'b0;
        in_ae = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        fill_random();
        frame_gap(2'd2);
        push_frame(2);
        drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
